// File: rtl/output_display.sv
// Output register with sequential binary-to-BCD conversion and a scanned 7-seg display.
// Optional signed display: define OUTPUT_DISPLAY_SIGNED_EN.
module output_display #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_signed,
    output logic [DATA_WIDTH-1:0] o_value,
    output logic                  o_busy,
    output logic [NUM_DIGITS-1:0] o_dig,
    output logic [6:0]            o_seg
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] shift_q;
    logic [BCD_W-1:0]      bcd_q;
    logic [BCD_W-1:0]      bcd_adj;
    logic [CNT_W-1:0]      cnt_q;
    logic                  neg_q;
    logic [BCD_W-1:0]      disp_bcd_q;
    logic                  disp_neg_q;
    logic                  commit;

    logic [DATA_WIDTH-1:0] load_mag;
    logic                  load_neg;

`ifdef OUTPUT_DISPLAY_SIGNED_EN
    assign load_neg = i_signed & i_data[DATA_WIDTH-1];
    // Negation wraps, so the most negative input yields its true magnitude.
    assign load_mag = load_neg
                    ? (~i_data + {{(DATA_WIDTH-1){1'b0}}, 1'b1})
                    : i_data;
`else
    logic sign_unused;
    assign sign_unused = i_signed;
    assign load_neg    = 1'b0;
    assign load_mag    = i_data;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (i_load) state_nx = CONVERT;
            end
            CONVERT: begin
                if (i_load) state_nx = CONVERT;
                else if (cnt_q == CNT_W'(1)) state_nx = COMMIT;
            end
            COMMIT: begin
                state_nx = i_load ? CONVERT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != IDLE);
        commit = (state == COMMIT) && !i_load;
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_value    <= '0;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            disp_bcd_q <= '0;
            disp_neg_q <= 1'b0;
        end else begin
            if (i_load) begin
                o_value <= i_data;
                shift_q <= load_mag;
                bcd_q   <= '0;
                cnt_q   <= CNT_W'(DATA_WIDTH);
                neg_q   <= load_neg;
            end else if (state == CONVERT) begin
                {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (commit) begin
                disp_bcd_q <= bcd_q;
                disp_neg_q <= neg_q;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [PRE_W-1:0]      pre_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_nx;
    logic                  pre_wrap;
    logic [BCD_W-1:0]      disp_bcd_nx;
    logic                  disp_neg_nx;
    logic [NUM_DIGITS-1:0] blank;
    logic                  above_zero;
    logic [6:0]            seg_nx;

    always_comb begin
        pre_wrap = (pre_q == PRE_W'(SCAN_DIV - 1));
        idx_nx   = idx_q;
        if (pre_wrap) begin
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) idx_nx = '0;
            else idx_nx = idx_q + IDX_W'(1);
        end
    end

    // Segments are built from the post-commit value so a commit shows on its own edge.
    always_comb begin
        disp_bcd_nx = commit ? bcd_q : disp_bcd_q;
        disp_neg_nx = commit ? neg_q : disp_neg_q;
        blank       = '0;
        above_zero  = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            above_zero = above_zero && (disp_bcd_nx[4*k +: 4] == 4'd0);
            blank[k]   = above_zero;
        end
        seg_nx = blank[idx_nx] ? 7'h00 : seg7(disp_bcd_nx[4*idx_nx +: 4]);
        if (disp_neg_nx && (idx_nx == IDX_W'(NUM_DIGITS - 1)))
            seg_nx = 7'h40;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
            o_dig <= NUM_DIGITS'(1);
            o_seg <= 7'h3F;
        end else begin
            pre_q <= pre_wrap ? '0 : pre_q + PRE_W'(1);
            idx_q <= idx_nx;
            o_dig <= NUM_DIGITS'(1) << idx_nx;
            o_seg <= seg_nx;
        end
    end

endmodule

// File: tb/tb_output_display.sv
// Scoreboard bench for output_display: commit latency, value, scan and segments.
module tb_output_display;

    localparam int SCAN = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_load = 1'b0;
    logic [7:0] i_data = '0;
    logic       i_signed = 1'b0;
    logic [7:0] o_value;
    logic       o_busy;
    logic [3:0] o_dig;
    logic [6:0] o_seg;

    output_display #(
        .DATA_WIDTH(8),
        .NUM_DIGITS(4),
        .SCAN_DIV(SCAN)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_load(i_load),
        .i_data(i_data),
        .i_signed(i_signed),
        .o_value(o_value),
        .o_busy(o_busy),
        .o_dig(o_dig),
        .o_seg(o_seg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]      val;
        int              cyc;
        logic [3:0][6:0] segs;
    } exp_t;

    exp_t q[$];
    int applied = 0;
    int miscmp = 0;

`ifdef OUTPUT_DISPLAY_SIGNED_EN
    localparam logic [6:0] NEG_SEG = 7'h40;
`else
    localparam logic [6:0] NEG_SEG = 7'h00;
`endif

    task automatic chk(input string nm, input int act, input int exp);
        applied++;
        if (act != exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic chk_reset();
        chk("rst_value", o_value, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_dig", o_dig, 1);
        chk("rst_seg", o_seg, 'h3F);
    endtask

    logic [3:0][6:0] shown;
    logic            prev_busy;
    logic [3:0]      prev_dig;
    int              run;

    always @(negedge clk) begin
        if (!rst_n) begin
            shown     = {7'h00, 7'h00, 7'h00, 7'h3F};
            prev_busy = 1'b0;
            prev_dig  = '0;
            run       = 0;
        end else begin
            if (prev_busy && !o_busy) begin
                if (q.size() == 0) begin
                    applied++;
                    miscmp++;
                    $display("FAIL unexpected_commit: got value %0h expected none at cycle %0d",
                             o_value, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("commit_latency", cyc, e.cyc + 9);
                    chk("o_value", o_value, e.val);
                    shown = e.segs;
                end
            end
            prev_busy = o_busy;

            chk("dig_onehot", int'($onehot(o_dig)), 1);
            if (o_dig != prev_dig) begin
                if (prev_dig != 4'd0) begin
                    chk("scan_hold", run, SCAN);
                    chk("scan_step", o_dig, {prev_dig[2:0], prev_dig[3]});
                end
                prev_dig = o_dig;
                run = 1;
            end else begin
                run++;
                if (run == SCAN + 1) chk("scan_hold", run, SCAN);
            end

            for (int k = 0; k < 4; k++) begin
                if (o_dig == (4'd1 << k)) chk($sformatf("seg_d%0d", k), o_seg, shown[k]);
            end
        end
    end

    task automatic do_load(input logic [7:0] d, input logic s, input logic [27:0] segs);
        exp_t e;
        @(negedge clk);
        i_data   = d;
        i_signed = s;
        i_load   = 1'b1;
        e.val  = d;
        e.cyc  = cyc + 1;
        e.segs = segs;
        q.push_back(e);
        @(negedge clk);
        i_load = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        q.delete();
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);

        do_load(8'hFF, 1'b0, {7'h00, 7'h5B, 7'h6D, 7'h6D});
        drain();

        @(negedge clk);
        i_data = 8'h07;
        i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        repeat (1) @(negedge clk);
        do_load(8'h2A, 1'b0, {7'h00, 7'h00, 7'h66, 7'h5B});
        drain();

        do_load(8'h00, 1'b0, {7'h00, 7'h00, 7'h00, 7'h3F});
        drain();

        do_load(8'h64, 1'b0, {7'h00, 7'h06, 7'h3F, 7'h3F});
        drain();

        do_load(8'h80, 1'b1, {NEG_SEG, 7'h06, 7'h5B, 7'h7F});
        drain();

        do_load(8'h80, 1'b0, {7'h00, 7'h06, 7'h5B, 7'h7F});
        drain();

        begin
            exp_t e;
            @(negedge clk);
            i_data   = 8'h09;
            i_signed = 1'b0;
            i_load   = 1'b1;
            repeat (4) @(negedge clk);
            e.val  = 8'h09;
            e.cyc  = cyc + 1;
            e.segs = {7'h00, 7'h00, 7'h00, 7'h6F};
            q.push_back(e);
            @(negedge clk);
            i_load = 1'b0;
        end
        drain();

        @(negedge clk);
        i_data = 8'h99;
        i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);

        do_load(8'h05, 1'b0, {7'h00, 7'h00, 7'h00, 7'h6D});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
        $finish;
    end

endmodule
